// File: rtl/exec_pkg.sv
// exec_pkg: shared definitions for the parametrised execute stage.
//   op_e    - 4-bit operation codes presented on in_op (11..15 unused)
//   fwd_e   - operand forward select encoding
//   CC_*    - bit positions inside the 4-bit {C,V,N,Z} condition code
//   state_e - sequencing states of the execute stage
package exec_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_NOT  = 4'd4,
    OP_XOR  = 4'd5,
    OP_PASS = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9,
    OP_MUL  = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    FWD_OWN     = 2'd0,
    FWD_RES     = 2'd1,
    FWD_WB      = 2'd2,
    FWD_OWN_ALT = 2'd3
  } fwd_e;

  localparam int CC_Z = 0;
  localparam int CC_N = 1;
  localparam int CC_V = 2;
  localparam int CC_C = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/exec_mul_iter.sv
// exec_mul_iter: radix-2 shift-add multiplier, low XLEN bits of an unsigned
// product, one partial product per cycle, XLEN cycles after start.
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - capture a/b and begin (ignored while abort is high)
//   abort      - discard the multiply in progress
//   a, b       - multiplicand, multiplier
//   done       - high during the final step; sum is the finished product then
//   sum        - accumulator plus the current partial product (next accumulator)
//   product    - accumulator; holds the finished product after the final step
module exec_mul_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] sum,
  output logic [XLEN-1:0] product
);

  localparam int CW = $clog2(XLEN);

  logic            run;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;

  assign sum     = acc + (mplier[0] ? mcand : '0);
  assign done    = run && (cnt == CW'(XLEN - 1));
  assign product = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (abort) begin
      run <= 1'b0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

  // Datapath needs no reset: it is always loaded by start before use.
  always_ff @(posedge clk) begin
    if (start && !abort) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (run) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= sum;
    end
  end

endmodule

// File: rtl/exec_stage_p.sv
// exec_stage_p: parametrised execute stage. Resolves operand forwarding,
// runs single-cycle ALU/shift ops or an iterative multiply, and registers
// result, store data, tag and condition codes into the EX/MEM boundary.
//   clk, rst_n          - clock, asynchronous active-low reset
//   flush               - synchronous kill of the multiply and the held output
//   in_valid/in_ready   - op handshake; in_op, in_a, in_b, in_store, in_tag
//   in_fwd_a/_b/_s      - forward selects (own / out_result / wb_data / own)
//   in_setcc            - op updates out_cc
//   wb_data             - writeback value for forwarding
//   out_valid/out_ready - output handshake; out_result, out_store, out_tag
//   out_cc              - {C,V,N,Z}
//   busy                - multiply in progress or waiting for the output slot
module exec_stage_p
  import exec_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [XLEN-1:0]  in_store,
  input  logic [1:0]       in_fwd_a,
  input  logic [1:0]       in_fwd_b,
  input  logic [1:0]       in_fwd_s,
  input  logic             in_setcc,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [XLEN-1:0]  wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [XLEN-1:0]  out_store,
  output logic [3:0]       out_cc,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int SH_W = $clog2(XLEN);

  function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel,
                                              input logic [XLEN-1:0] own,
                                              input logic [XLEN-1:0] res,
                                              input logic [XLEN-1:0] wb);
    case (fwd_e'(sel))
      FWD_RES: return res;
      FWD_WB:  return wb;
      default: return own;
    endcase
  endfunction

  function automatic logic [3:0] make_cc(input logic [XLEN-1:0] r,
                                         input logic c, input logic v);
    logic [3:0] cc;
    cc[CC_Z] = (r == '0);
    cc[CC_N] = r[XLEN-1];
    cc[CC_V] = v;
    cc[CC_C] = c;
    return cc;
  endfunction

  state_e                 state_q, state_d;
  op_e                    op;
  logic                   slot_free, accept, is_mul, mul_start, mul_load;
  logic [XLEN-1:0]        opa, opb, ops;
  logic signed [XLEN-1:0] a_s, b_s;
  logic [SH_W-1:0]        shamt;
  logic [XLEN-1:0]        alu_res;
  logic                   alu_c, alu_v, alu_known;
  logic [3:0]             alu_cc;
  logic                   mul_done;
  logic [XLEN-1:0]        mul_sum, mul_product, mul_res;
  logic [XLEN-1:0]        mul_store_p0;
  logic [TAG_W-1:0]       mul_tag_p0;
  logic                   mul_setcc_p0;

  assign op        = op_e'(in_op);
  assign is_mul    = (op == OP_MUL);
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state_q == ST_IDLE) && !flush && slot_free;
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != ST_IDLE);

  // Forwarding uses the output register as it stands in the accept cycle.
  assign opa   = fwd_mux(in_fwd_a, in_a, out_result, wb_data);
  assign opb   = fwd_mux(in_fwd_b, in_b, out_result, wb_data);
  assign ops   = fwd_mux(in_fwd_s, in_store, out_result, wb_data);
  assign a_s   = opa;
  assign b_s   = opb;
  assign shamt = opb[SH_W-1:0];

  always_comb begin
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_known = 1'b1;
    case (op)
      OP_ADD: begin
        {alu_c, alu_res} = {1'b0, opa} + {1'b0, opb};
        alu_v = (a_s[XLEN-1] == b_s[XLEN-1]) && (alu_res[XLEN-1] != a_s[XLEN-1]);
      end
      OP_SUB: begin
        alu_res = opa - opb;
        alu_c   = (opa < opb);
        alu_v   = (a_s[XLEN-1] != b_s[XLEN-1]) && (alu_res[XLEN-1] != a_s[XLEN-1]);
      end
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_NOT:  alu_res = ~opa;
      OP_XOR:  alu_res = opa ^ opb;
      OP_PASS: alu_res = opb;
      OP_SLL:  alu_res = opa << shamt;
      OP_SRL:  alu_res = opa >> shamt;
      OP_SRA:  alu_res = a_s >>> shamt;
      OP_MUL:  alu_res = '0;
      default: alu_known = 1'b0;
    endcase
  end

  assign alu_cc = make_cc(alu_res, alu_c, alu_v);

  exec_mul_iter #(.XLEN(XLEN)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .abort   (flush),
    .a       (opa),
    .b       (opb),
    .done    (mul_done),
    .sum     (mul_sum),
    .product (mul_product)
  );

  // On the final step the product is still combinational; in DRAIN it is held.
  assign mul_res = (state_q == ST_MUL) ? mul_sum : mul_product;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    mul_load  = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept && is_mul) begin
          mul_start = 1'b1;
          state_d   = ST_MUL;
        end
        ST_MUL: if (mul_done) begin
          if (slot_free) begin
            mul_load = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d  = ST_DRAIN;
          end
        end
        ST_DRAIN: if (slot_free) begin
          mul_load = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Stage p0: sideband captured with the multiply, consumed when it loads.
  always_ff @(posedge clk) begin
    if (mul_start) begin
      mul_store_p0 <= ops;
      mul_tag_p0   <= in_tag;
      mul_setcc_p0 <= in_setcc;
    end
  end

  // Stage p1: EX/MEM output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_store  <= '0;
      out_tag    <= '0;
      out_cc     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept && !is_mul) begin
      out_valid  <= 1'b1;
      out_result <= alu_res;
      out_store  <= ops;
      out_tag    <= in_tag;
      if (in_setcc && alu_known) out_cc <= alu_cc;
    end else if (mul_load) begin
      out_valid  <= 1'b1;
      out_result <= mul_res;
      out_store  <= mul_store_p0;
      out_tag    <= mul_tag_p0;
      if (mul_setcc_p0) out_cc <= make_cc(mul_res, 1'b0, 1'b0);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_stage_p.sv
// tb_exec_stage_p: scoreboard bench for exec_stage_p (XLEN=32, TAG_W=16).
// The driver pushes the expected output of each accepted op; a monitor pops
// and compares on every output handshake.
module tb_exec_stage_p;
  import exec_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 16;

  typedef struct {
    logic [31:0] res;
    logic [31:0] st;
    logic [3:0]  cc;
    logic [15:0] tag;
  } exp_t;

  logic              clk, rst_n, flush, in_valid, in_ready, in_setcc;
  logic [3:0]        in_op;
  logic [XLEN-1:0]   in_a, in_b, in_store, wb_data;
  logic [1:0]        in_fwd_a, in_fwd_b, in_fwd_s;
  logic [TAG_W-1:0]  in_tag, out_tag;
  logic              out_valid, out_ready, busy;
  logic [XLEN-1:0]   out_result, out_store;
  logic [3:0]        out_cc;

  exec_stage_p #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_store(in_store),
    .in_fwd_a(in_fwd_a), .in_fwd_b(in_fwd_b), .in_fwd_s(in_fwd_s),
    .in_setcc(in_setcc), .in_tag(in_tag), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_store(out_store),
    .out_cc(out_cc), .out_tag(out_tag), .busy(busy)
  );

  int          checks = 0;
  int          errors = 0;
  int          mode   = 0;   // 0: out_ready=1, 1: random, 2: out_ready=0
  exp_t        sb[$];
  logic [31:0] m_res = '0;   // value out_result will hold when the next op is accepted
  logic [3:0]  m_cc  = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (mode == 0)      out_ready = 1'b1;
    else if (mode == 2) out_ready = 1'b0;
    else                out_ready = ($urandom_range(3) != 0);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Monitor: a handshake happens on the next rising edge when both are high.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", {32'h0, out_result}, 64'hDEAD_0000_0000_0000);
        end else begin
          e = sb.pop_front();
          chk("sb_result", {32'h0, out_result}, {32'h0, e.res});
          chk("sb_store",  {32'h0, out_store},  {32'h0, e.st});
          chk("sb_cc",     {60'h0, out_cc},     {60'h0, e.cc});
          chk("sb_tag",    {48'h0, out_tag},    {48'h0, e.tag});
        end
      end
    end
  end

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] own,
                                      input logic [31:0] wb);
    if (sel == 2'd1) return m_res;
    if (sel == 2'd2) return wb;
    return own;
  endfunction

  // Reference model: arithmetic straight from the op definitions.
  task automatic model_accept(input logic [3:0] op, input logic [31:0] a, b, s,
                              input logic [1:0] fa, fb, fs, input logic sc,
                              input logic [15:0] tag, input logic [31:0] wb);
    logic [31:0] ea, eb, es, r;
    logic [63:0] u;
    longint      t, lim;
    int          sh;
    logic        c, v, known;
    ea = fwd(fa, a, wb);
    eb = fwd(fb, b, wb);
    es = fwd(fs, s, wb);
    sh = int'(eb[4:0]);
    lim = 64'sd2147483648;
    c = 1'b0; v = 1'b0; known = 1'b1; r = '0;
    case (op)
      4'd0: begin
        u = {32'h0, ea} + {32'h0, eb};
        r = u[31:0]; c = u[32];
        t = longint'($signed(ea)) + longint'($signed(eb));
        v = (t >= lim) || (t < -lim);
      end
      4'd1: begin
        r = ea - eb; c = (ea < eb);
        t = longint'($signed(ea)) - longint'($signed(eb));
        v = (t >= lim) || (t < -lim);
      end
      4'd2: r = ea & eb;
      4'd3: r = ea | eb;
      4'd4: r = ~ea;
      4'd5: r = ea ^ eb;
      4'd6: r = eb;
      4'd7: r = ea << sh;
      4'd8: r = ea >> sh;
      4'd9: r = $signed(ea) >>> sh;
      4'd10: begin
        u = {32'h0, ea} * {32'h0, eb};
        r = u[31:0];
      end
      default: known = 1'b0;
    endcase
    if (sc && known) m_cc = {c, v, r[31], (r == 32'h0)};
    m_res = r;
    sb.push_back('{r, es, m_cc, tag});
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, b, s,
                       input logic [1:0] fa, fb, fs, input logic sc,
                       input logic [15:0] tag, input logic [31:0] wb, output int waited);
    in_op = op; in_a = a; in_b = b; in_store = s;
    in_fwd_a = fa; in_fwd_b = fb; in_fwd_s = fs;
    in_setcc = sc; in_tag = tag; wb_data = wb; in_valid = 1'b1;
    waited = 0;
    #1;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
    else model_accept(op, a, b, s, fa, fb, fs, sc, tag, wb);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  int          w, w2;
  logic [3:0]  sv_cc;
  logic [31:0] sv_res;
  logic [31:0] pick[6];

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0;
    in_a = '0; in_b = '0; in_store = '0; in_fwd_a = '0; in_fwd_b = '0; in_fwd_s = '0;
    in_setcc = 1'b0; in_tag = '0; wb_data = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid",  {63'h0, out_valid}, 64'd0);
    chk("rst_result", {32'h0, out_result}, 64'd0);
    chk("rst_store",  {32'h0, out_store},  64'd0);
    chk("rst_tag",    {48'h0, out_tag},    64'd0);
    chk("rst_cc",     {60'h0, out_cc},     64'd0);
    chk("rst_busy",   {63'h0, busy},       64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_in_ready", {63'h0, in_ready}, 64'd1);
    @(negedge clk);

    // Signed overflow on ADD
    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h11, 0, 0, 0, 1, 16'h0001, 0, w);
    chk("add_ovf_valid", {63'h0, out_valid}, 64'd1);
    chk("add_ovf_res", {32'h0, out_result}, 64'h8000_0000);
    chk("add_ovf_cc", {60'h0, out_cc}, 64'b0110);

    // SUB equal, then borrow
    issue(OP_SUB, 32'd5, 32'd5, 0, 0, 0, 0, 1, 16'h0002, 0, w);
    chk("sub_eq_cc", {60'h0, out_cc}, 64'b0001);
    issue(OP_SUB, 32'd3, 32'd5, 0, 0, 0, 0, 1, 16'h0003, 0, w);
    chk("sub_brw_res", {32'h0, out_result}, 64'hFFFF_FFFE);
    chk("sub_brw_cc", {60'h0, out_cc}, 64'b1010);

    // Forwarding from out_result and wb_data
    issue(OP_ADD, 32'd1, 32'd2, 0, 0, 0, 0, 0, 16'h0004, 0, w);
    chk("fwd_base", {32'h0, out_result}, 64'd3);
    issue(OP_ADD, 32'hDEAD, 32'd4, 0, 1, 0, 0, 0, 16'h0005, 0, w);
    chk("fwd_res", {32'h0, out_result}, 64'd7);
    issue(OP_ADD, 32'd1, 32'h55, 0, 0, 2, 0, 0, 16'h0006, 32'd9, w);
    chk("fwd_wb", {32'h0, out_result}, 64'd10);
    chk("cc_hold", {60'h0, out_cc}, 64'b1010);

    // MUL blocks intake for XLEN cycles
    issue(OP_MUL, 32'h1234, 32'h10, 32'hCAFE, 0, 0, 0, 0, 16'h0007, 0, w);
    chk("mul_busy", {63'h0, busy}, 64'd1);
    issue(OP_ADD, 32'd2, 32'd2, 0, 0, 0, 0, 0, 16'h0008, 0, w2);
    chk("mul_stall_cycles", 64'(w2), 64'd32);
    chk("post_mul_add", {32'h0, out_result}, 64'd4);
    chk("post_mul_busy", {63'h0, busy}, 64'd0);
    wait_drain("drain_1");

    // MUL completing while downstream stalls: result loads and holds
    mode = 2;
    @(negedge clk);
    issue(OP_MUL, 32'hABCD, 32'h100, 32'h77, 0, 0, 0, 0, 16'h0009, 0, w);
    w2 = 0;
    while (!out_valid && w2 < 40) begin
      @(negedge clk);
      #1;
      w2++;
    end
    chk("hold_mul_lat", 64'(w2), 64'd32);
    chk("hold_res", {32'h0, out_result}, 64'h00AB_CD00);
    chk("hold_busy", {63'h0, busy}, 64'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("hold_valid", {63'h0, out_valid}, 64'd1);
    chk("hold_res2", {32'h0, out_result}, 64'h00AB_CD00);
    chk("hold_tag", {48'h0, out_tag}, 64'h0009);
    chk("hold_in_ready", {63'h0, in_ready}, 64'd0);
    mode = 0;
    wait_drain("drain_2");

    // Flush in MUL cycle 10 with an op presented
    @(negedge clk);
    sv_cc = m_cc; sv_res = m_res;
    issue(OP_MUL, 32'h0, 32'h5, 0, 0, 0, 0, 1, 16'h000A, 0, w);
    repeat (9) @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_op = OP_ADD; in_a = 32'd1; in_b = 32'd1;
    in_setcc = 1'b1; in_fwd_a = 0; in_fwd_b = 0;
    #1;
    chk("flush_in_ready", {63'h0, in_ready}, 64'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_busy", {63'h0, busy}, 64'd0);
    chk("flush_valid", {63'h0, out_valid}, 64'd0);
    chk("flush_cc", {60'h0, out_cc}, {60'h0, sv_cc});
    void'(sb.pop_back());
    m_cc = sv_cc; m_res = sv_res;
    repeat (40) @(negedge clk);
    chk("flush_no_out", {63'h0, out_valid}, 64'd0);
    chk("flush_res_kept", {32'h0, out_result}, {32'h0, sv_res});

    // Reset in the middle of a multiply
    issue(OP_MUL, 32'h3, 32'h7, 0, 0, 0, 0, 1, 16'h000B, 0, w);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", {63'h0, busy}, 64'd0);
    chk("mrst_valid", {63'h0, out_valid}, 64'd0);
    chk("mrst_res", {32'h0, out_result}, 64'd0);
    chk("mrst_cc", {60'h0, out_cc}, 64'd0);
    void'(sb.pop_back());
    m_res = '0; m_cc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("mrst_no_out", {63'h0, out_valid}, 64'd0);

    // Randomized traffic with random back-pressure
    mode = 1;
    pick[0] = 32'h0; pick[1] = 32'h1; pick[2] = 32'h7FFF_FFFF;
    pick[3] = 32'h8000_0000; pick[4] = 32'hFFFF_FFFF; pick[5] = 32'h0;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra, rb;
      pick[5] = $urandom;
      ra = ($urandom_range(1) != 0) ? $urandom : pick[$urandom_range(5)];
      rb = ($urandom_range(1) != 0) ? $urandom : pick[$urandom_range(5)];
      if ($urandom_range(3) == 0) @(negedge clk);
      issue(4'($urandom_range(15)), ra, rb, $urandom,
            2'($urandom_range(3)), 2'($urandom_range(3)), 2'($urandom_range(3)),
            1'($urandom_range(1)), 16'($urandom), $urandom, w);
    end
    mode = 0;
    wait_drain("drain_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
